// File: rtl/pad_ctrl_pkg.sv
// Pad controller shared definitions: register word offsets (PADDR[6:2]),
// per-pad config type, and boot FSM state encoding.
package pad_ctrl_pkg;

  // Word indices (byte offset >> 2)
  localparam logic [4:0] OFF_PADCFG_LAST = 5'h0F;  // 0x00..0x3C PADCFG0..15
  localparam logic [4:0] OFF_PADIN_LO    = 5'h10;  // 0x40
  localparam logic [4:0] OFF_PADIN_HI    = 5'h11;  // 0x44
  localparam logic [4:0] OFF_BOOT        = 5'h12;  // 0x48
  localparam logic [4:0] OFF_LOCK        = 5'h13;  // 0x4C

  typedef logic [5:0] pad_cfg_t;

  // bit0 = 1 disables the pull; pad frame drives PEN = ~bit0
  localparam int PADCFG_PULL_DIS_BIT = 0;

  typedef enum logic {
    BOOT_WAIT = 1'b0,
    BOOT_DONE = 1'b1
  } boot_state_e;

  // Read-only registers reject writes
  function automatic logic is_ro(input logic [4:0] idx);
    return (idx == OFF_PADIN_LO) || (idx == OFF_PADIN_HI) || (idx == OFF_BOOT);
  endfunction

endpackage

// File: rtl/pad_in_sync.sv
// Multi-flop level synchronizer for asynchronous pad inputs.
// Ports:
//   clk_i   clock
//   rst_ni  async reset, active low (all stages cleared)
//   d_i     raw asynchronous levels
//   q_o     levels after STAGES flops
module pad_in_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/apb_pad_ctrl.sv
// APB3 slave owning per-pad configuration for the pad frame, synchronized
// pad-input readback, a set-only config lock and a one-shot boot strap capture.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   PADDR..PSLVERR       APB3 slave, zero wait states
//   pad_in_i             raw pad input levels (async)
//   bootsel_i            raw boot strap level (async)
//   pad_cfg_o            NPAD x 6-bit config, pad p at [6p+5:6p]
//   bootsel_o            captured boot select
//   boot_valid_o         bootsel_o is valid
module apb_pad_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int NPAD            = 48,
  parameter int APB_ADDR_WIDTH  = 12,
  parameter int SYNC_STAGES     = 2,
  parameter int BOOT_SAMPLE_CYC = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NPAD-1:0]           pad_in_i,
  input  logic                      bootsel_i,
  output logic [NPAD*6-1:0]         pad_cfg_o,
  output logic                      bootsel_o,
  output logic                      boot_valid_o
);

  logic [NPAD-1:0]           pad_sync;
  logic                      boot_sync;
  pad_cfg_t [NPAD-1:0]       cfg_q;
  logic                      lock_q;
  boot_state_e               state_q;
  logic [7:0]                cnt_q;
  logic                      bootsel_q;
  logic                      boot_valid_q;

  // ---------------------------------------------------------------- sync
  pad_in_sync #(.WIDTH(NPAD), .STAGES(SYNC_STAGES)) u_pad_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (pad_in_i),
    .q_o   (pad_sync)
  );

  pad_in_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_boot_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (bootsel_i),
    .q_o   (boot_sync)
  );

  // ---------------------------------------------------------------- decode
  logic [4:0] idx;
  logic       hi_bad;
  logic       access, err, wr_ok, rd_ok, cfg_we, lock_we;

  assign idx = PADDR[6:2];

  // Any address bit above the decoded window makes the access unmapped,
  // so e.g. 0x80 does not alias onto PADCFG0.
  generate
    if (APB_ADDR_WIDTH > 7) begin : g_hi
      assign hi_bad = |PADDR[APB_ADDR_WIDTH-1:7];
    end else begin : g_nohi
      assign hi_bad = 1'b0;
    end
  endgenerate

  // Gated by rst_ni so an access held across reset shows no error/data.
  assign access = PSEL & PENABLE & rst_ni;

  assign err = access & (hi_bad
                       | (idx > OFF_LOCK)
                       | (PWRITE & is_ro(idx))
                       | (PWRITE & (idx <= OFF_PADCFG_LAST) & lock_q));

  assign wr_ok   = access & PWRITE & ~err;
  assign rd_ok   = access & ~PWRITE & ~err;
  assign cfg_we  = wr_ok & (idx <= OFF_PADCFG_LAST);
  assign lock_we = wr_ok & (idx == OFF_LOCK) & PWDATA[0];

  assign PREADY  = 1'b1;
  assign PSLVERR = err;

  // ---------------------------------------------------------------- regs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      // Bytes for pads >= NPAD simply have no storage behind them.
      for (int p = 0; p < NPAD; p++) begin
        if (cfg_we && idx[3:0] == 4'(p / 4))
          cfg_q[p] <= PWDATA[(p % 4) * 8 +: 6];
      end
      if (lock_we) lock_q <= 1'b1;
    end
  end

  always_comb begin
    pad_cfg_o = '0;
    for (int p = 0; p < NPAD; p++) pad_cfg_o[p*6 +: 6] = cfg_q[p];
  end

  // ---------------------------------------------------------------- boot FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= BOOT_WAIT;
      cnt_q        <= '0;
      bootsel_q    <= 1'b0;
      boot_valid_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT_WAIT: begin
          if (cnt_q == 8'(BOOT_SAMPLE_CYC - 1)) begin
            bootsel_q    <= boot_sync;
            boot_valid_q <= 1'b1;
            state_q      <= BOOT_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;  // BOOT_DONE is terminal until reset
      endcase
    end
  end

  assign bootsel_o    = bootsel_q;
  assign boot_valid_o = boot_valid_q;

  // ---------------------------------------------------------------- readback
  pad_cfg_t [63:0] cfg_ext;
  logic     [63:0] padin_ext;
  logic     [31:0] rdata;

  always_comb begin
    cfg_ext   = '0;
    padin_ext = '0;
    for (int p = 0; p < NPAD; p++) begin
      cfg_ext[p]   = cfg_q[p];
      padin_ext[p] = pad_sync[p];
    end
  end

  always_comb begin
    rdata = '0;
    if (idx <= OFF_PADCFG_LAST) begin
      for (int j = 0; j < 4; j++) rdata[j*8 +: 6] = cfg_ext[{idx[3:0], 2'(j)}];
    end else begin
      case (idx)
        OFF_PADIN_LO: rdata = padin_ext[31:0];
        OFF_PADIN_HI: rdata = padin_ext[63:32];
        OFF_BOOT:     rdata = {30'b0, boot_valid_q, bootsel_q};
        OFF_LOCK:     rdata = {31'b0, lock_q};
        default:      rdata = '0;
      endcase
    end
  end

  assign PRDATA = rd_ok ? rdata : 32'h0;

  // Bits that exist on the bus but carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{PADDR[1:0], PWDATA};

endmodule

// File: tb/tb_apb_pad_ctrl.sv
module tb_apb_pad_ctrl;
  localparam int NPAD = 48;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [11:0]       PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE, PSEL, PENABLE;
  logic [31:0]       PRDATA;
  logic              PREADY, PSLVERR;
  logic [NPAD-1:0]   pad_in_i;
  logic              bootsel_i;
  logic [NPAD*6-1:0] pad_cfg_o;
  logic              bootsel_o, boot_valid_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  apb_pad_ctrl #(.NPAD(NPAD), .APB_ADDR_WIDTH(12), .SYNC_STAGES(2), .BOOT_SAMPLE_CYC(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .pad_in_i(pad_in_i), .bootsel_i(bootsel_i), .pad_cfg_o(pad_cfg_o),
    .bootsel_o(bootsel_o), .boot_valid_o(boot_valid_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, output logic e);
    @(posedge clk_i); #1;
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk_i); #1;
    PENABLE = 1'b1;
    #1 e = PSLVERR;
    @(posedge clk_i); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(posedge clk_i); #1;
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk_i); #1;
    PENABLE = 1'b1;
    #1 begin d = PRDATA; e = PSLVERR; end
    @(posedge clk_i); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst_ni = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    pad_in_i = '0; bootsel_i = 1'b1;

    // 1 + 4: reset state, boot valid exactly at edge 4 with strap held high
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_pad_cfg", 64'(pad_cfg_o[63:0]), 64'h0);
    check("rst_pslverr", 64'(PSLVERR), 64'h0);
    check("rst_boot_valid", 64'(boot_valid_o), 64'h0);
    check("pready", 64'(PREADY), 64'h1);
    @(negedge clk_i) rst_ni = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk_i); #1;
      check($sformatf("boot_valid_edge%0d", e), 64'(boot_valid_o), (e >= 4) ? 64'h1 : 64'h0);
    end
    check("bootsel_capt", 64'(bootsel_o), 64'h1);
    apb_rd(12'h000, rd, er);
    check("rd_padcfg0_rst", 64'(rd), 64'h0);
    bootsel_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    check("bootsel_held", 64'(bootsel_o), 64'h1);
    apb_rd(12'h048, rd, er);
    check("rd_boot", 64'(rd), 64'h3);

    // 2: PADCFG writes and out-of-range pads
    apb_wr(12'h004, 32'h3F01_2A15, er);
    check("wr04_err", 64'(er), 64'h0);
    check("pad4", 64'(pad_cfg_o[4*6 +: 6]), 64'h15);
    check("pad5", 64'(pad_cfg_o[5*6 +: 6]), 64'h2A);
    check("pad6", 64'(pad_cfg_o[6*6 +: 6]), 64'h01);
    check("pad7", 64'(pad_cfg_o[7*6 +: 6]), 64'h3F);
    apb_rd(12'h004, rd, er);
    check("rd04", 64'(rd), 64'h3F01_2A15);
    apb_wr(12'h02C, 32'hFFFF_FFFF, er);
    check("wr2c_err", 64'(er), 64'h0);
    apb_rd(12'h02C, rd, er);
    check("rd2c", 64'(rd), 64'h3F3F_3F3F);
    check("pad47", 64'(pad_cfg_o[47*6 +: 6]), 64'h3F);
    apb_wr(12'h030, 32'hFFFF_FFFF, er);
    check("wr30_err", 64'(er), 64'h0);
    apb_rd(12'h030, rd, er);
    check("rd30", 64'(rd), 64'h0);

    // 3: pad input sync latency, read access held open (no side effects)
    @(posedge clk_i); #1;
    PADDR = 12'h040; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b1;
    @(negedge clk_i);
    pad_in_i[5] = 1'b1; pad_in_i[40] = 1'b1;
    @(posedge clk_i); #1;
    check("padin_edge1", 64'(PRDATA), 64'h0);
    @(posedge clk_i); #1;
    check("padin_edge2", 64'(PRDATA), 64'h20);
    PSEL = 1'b0; PENABLE = 1'b0;
    apb_rd(12'h044, rd, er);
    check("padin_hi", 64'(rd), 64'h100);

    // 5: lock
    apb_wr(12'h04C, 32'h1, er);
    check("lock_wr_err", 64'(er), 64'h0);
    apb_wr(12'h000, 32'h1, er);
    check("locked_wr_err", 64'(er), 64'h1);
    check("locked_pad0", 64'(pad_cfg_o[5:0]), 64'h0);
    apb_wr(12'h04C, 32'h0, er);
    apb_rd(12'h04C, rd, er);
    check("lock_sticky", 64'(rd), 64'h1);
    apb_wr(12'h000, 32'h1, er);
    check("still_locked_err", 64'(er), 64'h1);

    // 6: RO write, unmapped read, reset mid-access
    apb_wr(12'h040, 32'hFFFF_FFFF, er);
    check("ro_wr_err", 64'(er), 64'h1);
    apb_rd(12'h080, rd, er);
    check("unmap_err", 64'(er), 64'h1);
    check("unmap_data", 64'(rd), 64'h0);
    @(posedge clk_i); #1;
    PADDR = 12'h080; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b1;
    #1 check("pre_rst_err", 64'(PSLVERR), 64'h1);
    #1 rst_ni = 1'b0;
    #1;
    check("midrst_err", 64'(PSLVERR), 64'h0);
    check("midrst_prdata", 64'(PRDATA), 64'h0);
    check("midrst_cfg", 64'(pad_cfg_o[47:0]), 64'h0);
    check("midrst_pad47", 64'(pad_cfg_o[47*6 +: 6]), 64'h0);
    check("midrst_boot", 64'({bootsel_o, boot_valid_o}), 64'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    apb_wr(12'h000, 32'h1, er);
    check("unlock_after_rst", 64'(er), 64'h0);
    check("pad0_after_rst", 64'(pad_cfg_o[5:0]), 64'h1);
    repeat (4) @(posedge clk_i);
    #1;
    check("boot_revalid", 64'({bootsel_o, boot_valid_o}), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
